lif_layer_scheduler: RTL and testbench
======================================

Name: lif_layer_scheduler

Overview:
- Time-multiplexed controller that shares one leaky-integrate-and-fire update datapath among NUM_NEURONS neurons.
- Each timestep it:
  - captures an input spike vector and leak factor on a start pulse;
  - sweeps every neuron index, one update per cycle, against a membrane register array;
  - publishes the resulting output spike vector with a done pulse.
- Sits between the spike router (upstream) and the layer output/next layer (downstream).

Parameters:
- NUM_NEURONS, 8, neurons served per timestep (>=2).
- IDX_W, $clog2(NUM_NEURONS), neuron index width.
- WEIGHT, 16'd64, potential added per input spike.
- THRESHOLD, 16'd256, firing threshold; fire when potential >= THRESHOLD.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin one timestep; accepted only in IDLE.
- spike_in  in  NUM_NEURONS  input spike per neuron, sampled with accepted start.
- leak_factor  in  leak_t (8)  subtractive leak, sampled with accepted start.
- clear_mem  in  1  zero all potentials; accepted only in IDLE.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse at end of timestep.
- spike_out  out  NUM_NEURONS  output spikes of last completed timestep.
- start_dropped  out  1  one-cycle pulse when start arrives while busy.
- rd_idx  in  IDX_W  debug read index.
- rd_potential  out  membrane_t (16)  combinational read of potential[rd_idx].

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- Reset, including mid-timestep:
  - state=IDLE, idx=0;
  - all potentials=0;
  - spike_out=0, done=0, busy=0, start_dropped=0;
  - captured spike/leak registers cleared.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - start=1: capture spike_in and leak_factor, set idx=0, go to RUN.
  - start and clear_mem both high: clear_mem wins; potentials zeroed, start ignored, no start_dropped.
- RUN: one neuron per cycle, using the captured vector and leak (later input changes are ignored).
  - v = potential[idx]
  - vl = (v > leak) ? v - leak : 0 (floor at 0)
  - vi = vl + (spike[idx] ? WEIGHT : 0), saturating at 16'hFFFF
  - vi >= THRESHOLD: fire; potential[idx] <= 0; spike_work[idx] <= 1
  - otherwise: potential[idx] <= vi; spike_work[idx] <= 0
  - idx==NUM_NEURONS-1: go to DONE; otherwise idx++.
- DONE: done=1 for exactly one cycle; spike_out <= spike_work; go to IDLE.
- spike_out holds until the next DONE.
- Latency: start accepted at edge T; done high in cycle T+NUM_NEURONS+1; next start accepted in the cycle after done.
- start while busy: ignored, start_dropped pulses in the same cycle, state untouched.
- clear_mem while busy: ignored.
- rd_potential reflects the array after the most recent edge.

Decomposition:
- neuron_pkg holds shared types: leak_t (logic [7:0]), membrane_t (logic [15:0]), sched_state_e enum (IDLE, RUN, DONE).
- Sub-module lif_update_core: purely combinational.
  - Inputs: v, leak, spike.
  - Outputs: v_next, fire.
  - Implements the leak/integrate/saturate/threshold arithmetic; instantiated once.
- Scheduler holds the FSM, index counter, potential array and spike vectors.

Test Plan:
- Reset then idle: busy=0, done=0, spike_out=0, rd_potential=0 for all idx; start with spike_in=0 gives done exactly 9 cycles after start (NUM_NEURONS=8).
- Integration to fire, neuron 3 spiking every timestep, leak=6:
  - potential after each timestep: 64, 122, 180, 238;
  - 5th timestep: spike_out[3]=1 and potential=0;
  - all other bits 0.
- Decay floor: one spike on neuron 0 (64), then 11 empty timesteps with leak=6 -> potentials 58,52,...,4,0; a further timestep stays 0.
- Saturation: leak=0, THRESHOLD overridden to 16'hFFFF, WEIGHT=16'h8000 -> potential 8000, then saturates to FFFF (not wrap to 0) and fires.
- Busy collisions:
  - start during RUN -> start_dropped pulse, done count unchanged;
  - clear_mem during RUN -> ignored;
  - clear_mem+start in IDLE -> potentials 0, no timestep runs.
- Reset mid-RUN at idx=4 -> next cycle IDLE, all potentials 0, spike_out=0, no done pulse.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types for the LIF layer scheduler and its update core.
package neuron_pkg;

  typedef logic [7:0]  leak_t;
  typedef logic [15:0] membrane_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sched_state_e;

endpackage

// File: rtl/lif_update_core.sv
// Combinational leaky-integrate-and-fire update for a single neuron:
// subtractive leak floored at zero, saturating spike integration, threshold fire.
module lif_update_core
  import neuron_pkg::*;
#(
  parameter membrane_t WEIGHT    = 16'd64,
  parameter membrane_t THRESHOLD = 16'd256
) (
  input  membrane_t v,
  input  leak_t     leak,
  input  logic      spike,
  output membrane_t v_next,
  output logic      fire
);

  membrane_t   leak_ext;
  membrane_t   v_leaked;
  logic [16:0] v_sum;
  membrane_t   v_int;

  // Leak, integrate with saturation, then compare against the firing threshold
  always_comb begin
    leak_ext = membrane_t'(leak);
    v_leaked = (v > leak_ext) ? (v - leak_ext) : '0;
    v_sum    = {1'b0, v_leaked} + {1'b0, (spike ? WEIGHT : 16'd0)};
    v_int    = v_sum[16] ? 16'hFFFF : v_sum[15:0];
    fire     = (v_int >= THRESHOLD);
    v_next   = fire ? '0 : v_int;
  end

endmodule

// File: rtl/lif_layer_scheduler.sv
// Time-multiplexed LIF layer: one shared update core swept across all neurons,
// one neuron per cycle, with a captured spike vector and leak per timestep.
module lif_layer_scheduler
  import neuron_pkg::*;
#(
  parameter int        NUM_NEURONS = 8,
  parameter int        IDX_W       = $clog2(NUM_NEURONS),
  parameter membrane_t WEIGHT      = 16'd64,
  parameter membrane_t THRESHOLD   = 16'd256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_NEURONS-1:0] spike_in,
  input  leak_t                  leak_factor,
  input  logic                   clear_mem,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_NEURONS-1:0] spike_out,
  output logic                   start_dropped,
  input  logic [IDX_W-1:0]       rd_idx,
  output membrane_t              rd_potential
);

  sched_state_e           state_reg, state_next;
  logic [IDX_W-1:0]       idx_reg;
  logic [NUM_NEURONS-1:0] spike_cap_reg;
  leak_t                  leak_cap_reg;
  logic [NUM_NEURONS-1:0] spike_work_reg;
  logic [NUM_NEURONS-1:0] spike_out_reg;
  logic                   done_reg;
  membrane_t              potential_reg [NUM_NEURONS];

  logic                   last_idx;
  membrane_t              v_next;
  logic                   fire;

  assign last_idx = (idx_reg == IDX_W'(NUM_NEURONS - 1));

  lif_update_core #(
    .WEIGHT    (WEIGHT),
    .THRESHOLD (THRESHOLD)
  ) u_core (
    .v      (potential_reg[idx_reg]),
    .leak   (leak_cap_reg),
    .spike  (spike_cap_reg[idx_reg]),
    .v_next (v_next),
    .fire   (fire)
  );

  // Next-state logic; clear_mem takes priority over start in IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!clear_mem && start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_idx) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, sweep index, captured inputs, membrane array and spike vectors
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      spike_cap_reg  <= '0;
      leak_cap_reg   <= '0;
      spike_work_reg <= '0;
      spike_out_reg  <= '0;
      done_reg       <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        potential_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      // done rises together with the newly published spike_out
      done_reg  <= (state_reg == DONE);
      case (state_reg)
        IDLE: begin
          if (clear_mem) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
              potential_reg[i] <= '0;
            end
          end else if (start) begin
            spike_cap_reg <= spike_in;
            leak_cap_reg  <= leak_factor;
            idx_reg       <= '0;
          end
        end
        RUN: begin
          potential_reg[idx_reg]  <= v_next;
          spike_work_reg[idx_reg] <= fire;
          if (!last_idx) begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        DONE: begin
          spike_out_reg <= spike_work_reg;
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;
  assign spike_out     = spike_out_reg;
  assign start_dropped = start && busy && !rst;
  assign rd_potential  = potential_reg[rd_idx];

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// Directed self-checking bench for lif_layer_scheduler (8 neurons), plus a
// second instance with overridden WEIGHT/THRESHOLD for the saturation case.
module tb_lif_layer_scheduler;
  import neuron_pkg::*;

  logic       clk = 1'b0;
  logic       rst;

  logic       start, clear_mem, busy, done, start_dropped;
  logic [7:0] spike_in, spike_out;
  leak_t      leak_factor;
  logic [2:0] rd_idx;
  membrane_t  rd_potential;

  logic       start_s, clear_s, busy_s, done_s, start_dropped_s;
  logic [7:0] spike_s, spike_out_s;
  leak_t      leak_s;
  logic [2:0] rd_idx_s;
  membrane_t  rd_potential_s;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int lat;
  int d0;

  membrane_t integ_exp [4]  = '{16'd64, 16'd122, 16'd180, 16'd238};
  membrane_t decay_exp [12] = '{16'd58, 16'd52, 16'd46, 16'd40, 16'd34, 16'd28,
                                16'd22, 16'd16, 16'd10, 16'd4, 16'd0, 16'd0};

  always #5 clk = ~clk;

  lif_layer_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .spike_in      (spike_in),
    .leak_factor   (leak_factor),
    .clear_mem     (clear_mem),
    .busy          (busy),
    .done          (done),
    .spike_out     (spike_out),
    .start_dropped (start_dropped),
    .rd_idx        (rd_idx),
    .rd_potential  (rd_potential)
  );

  lif_layer_scheduler #(
    .WEIGHT    (16'h8000),
    .THRESHOLD (16'hFFFF)
  ) dut_sat (
    .clk           (clk),
    .rst           (rst),
    .start         (start_s),
    .spike_in      (spike_s),
    .leak_factor   (leak_s),
    .clear_mem     (clear_s),
    .busy          (busy_s),
    .done          (done_s),
    .spike_out     (spike_out_s),
    .start_dropped (start_dropped_s),
    .rd_idx        (rd_idx_s),
    .rd_potential  (rd_potential_s)
  );

  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pot(input int i, input membrane_t exp, input string tag);
    rd_idx = i[2:0];
    #1;
    check(tag, {16'd0, rd_potential}, {16'd0, exp});
  endtask

  // Launch one timestep from a negedge and wait (bounded) for its done pulse.
  // Inputs are scrambled right after acceptance to confirm they were captured.
  task automatic run_ts(input logic [7:0] sp, input leak_t lk, input bit sat, output int lt);
    if (sat) begin
      start_s = 1'b1; spike_s = sp; leak_s = lk;
    end else begin
      start = 1'b1; spike_in = sp; leak_factor = lk;
    end
    @(posedge clk);
    #1;
    start = 1'b0; start_s = 1'b0;
    if (sat) begin spike_s = ~sp; leak_s = 8'hFF; end
    else     begin spike_in = ~sp; leak_factor = 8'hFF; end
    lt = 0;
    while (lt < 50) begin
      @(posedge clk);
      lt++;
      @(negedge clk);
      if (sat ? done_s : done) break;
    end
    $display("timestep sat=%0d spikes=%02h leak=%0d latency=%0d", sat, sp, lk, lt);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear_mem = 1'b0; spike_in = '0; leak_factor = '0; rd_idx = '0;
    start_s = 1'b0; clear_s = 1'b0; spike_s = '0; leak_s = '0; rd_idx_s = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_spike_out", {24'd0, spike_out}, 32'd0);
    check("rst_start_dropped", {31'd0, start_dropped}, 32'd0);
    for (int i = 0; i < 8; i++) check_pot(i, 16'd0, "rst_pot");

    // Saturation: 0x8000 then 0x8000+0x8000 clamps to 0xFFFF and fires
    @(negedge clk);
    run_ts(8'h01, 8'd0, 1'b1, lat);
    check("sat_lat1", lat, 32'd9);
    check("sat_spike1", {24'd0, spike_out_s}, 32'd0);
    rd_idx_s = 3'd0; #1;
    check("sat_pot1", {16'd0, rd_potential_s}, 32'h8000);
    @(negedge clk);
    run_ts(8'h01, 8'd0, 1'b1, lat);
    check("sat_spike2", {24'd0, spike_out_s}, 32'h01);
    rd_idx_s = 3'd0; #1;
    check("sat_pot2", {16'd0, rd_potential_s}, 32'h0);

    // Empty timestep latency
    @(negedge clk);
    run_ts(8'h00, 8'd0, 1'b0, lat);
    check("empty_latency", lat, 32'd9);
    check("empty_done", {31'd0, done}, 32'd1);
    check("empty_spike_out", {24'd0, spike_out}, 32'd0);

    // Integration to fire on neuron 3 with leak 6
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      run_ts(8'h08, 8'd6, 1'b0, lat);
      check("integ_spike_out", {24'd0, spike_out}, 32'd0);
      check_pot(3, integ_exp[t], "integ_pot3");
    end
    check_pot(2, 16'd0, "integ_pot2");
    @(negedge clk);
    run_ts(8'h08, 8'd6, 1'b0, lat);
    check("integ_fire", {24'd0, spike_out}, 32'h08);
    check_pot(3, 16'd0, "integ_fire_pot3");

    // Decay floor on neuron 0
    @(negedge clk);
    run_ts(8'h01, 8'd6, 1'b0, lat);
    check_pot(0, 16'd64, "decay_pot0_init");
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      run_ts(8'h00, 8'd6, 1'b0, lat);
      check_pot(0, decay_exp[t], "decay_pot0");
    end
    check("decay_spike_out", {24'd0, spike_out}, 32'd0);

    // Busy collisions: start and clear_mem during RUN are ignored
    @(negedge clk);
    run_ts(8'h20, 8'd0, 1'b0, lat);
    check_pot(5, 16'd64, "coll_pot5_init");
    @(negedge clk);
    start = 1'b1; spike_in = 8'h00; leak_factor = 8'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    start = 1'b1; clear_mem = 1'b1;
    #1;
    check("coll_start_dropped", {31'd0, start_dropped}, 32'd1);
    check("coll_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0; clear_mem = 1'b0;
    #1;
    check("coll_dropped_clears", {31'd0, start_dropped}, 32'd0);
    repeat (15) @(negedge clk);
    #1;
    check("coll_done_count", done_cnt - d0, 32'd1);
    check_pot(5, 16'd64, "coll_pot5_kept");

    // clear_mem + start in IDLE: memory cleared, no timestep runs
    @(negedge clk);
    start = 1'b1; clear_mem = 1'b1; spike_in = 8'hFF;
    #1;
    check("clr_no_drop", {31'd0, start_dropped}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0; clear_mem = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd0);
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    #1;
    check("clr_done_count", done_cnt - d0, 32'd0);
    check_pot(5, 16'd0, "clr_pot5");

    // Fire every neuron, then reset in the middle of the next sweep
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      run_ts(8'hFF, 8'd0, 1'b0, lat);
    end
    check("all_fire", {24'd0, spike_out}, 32'hFF);
    @(negedge clk);
    start = 1'b1; spike_in = 8'hFF; leak_factor = 8'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_pot(2, 16'd64, "midrun_pot2_progress");
    rst = 1'b1;
    d0 = done_cnt;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_spike_out", {24'd0, spike_out}, 32'd0);
    for (int i = 0; i < 8; i++) check_pot(i, 16'd0, "midrst_pot");
    repeat (15) @(negedge clk);
    #1;
    check("midrst_no_done", done_cnt - d0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
